eth_tx_arbiter: RTL and testbench

ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

---
 rtl/eth_pkg.sv | 20 ++
 rtl/eth_rr_arbiter.sv | 40 ++++
 rtl/eth_tx_arbiter.sv | 155 +++++++++++++++
 tb/tb_eth_tx_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
`default_nettype none
// ==========================================================================
// Package  : eth_pkg
// Summary  : Shared types and constants for the Ethernet TX frame arbiter.
// Revision : 1.0 - initial release
// ==========================================================================
package eth_pkg;

  // Arbiter control states: waiting, forwarding a frame, discarding a tail
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DROP = 2'd2
  } arb_state_e;

  // Longest frame (in beats) forwarded before forced truncation
  localparam int C_MAX_BEATS = 1522;

endpackage
`default_nettype wire

// File: rtl/eth_rr_arbiter.sv
`default_nettype none
// ==========================================================================
// Module   : eth_rr_arbiter
// Summary  : Combinational round-robin picker. Returns the first requester
//            strictly after the last-granted index, wrapping to 0.
// Revision : 1.0 - initial release
// ==========================================================================
module eth_rr_arbiter #(
  parameter int N_PORTS = 2,
  parameter int IDX_W   = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [IDX_W-1:0]   o_grant,
  output logic               o_valid
);

  localparam logic [IDX_W:0] C_NPORTS = (IDX_W+1)'(N_PORTS);

  logic [IDX_W:0] w_sum;

  // Scan last+1 .. last+N_PORTS (mod N_PORTS); the last candidate is the previous winner itself
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_sum   = '0;
    for (int i = 1; i <= N_PORTS; i++) begin
      w_sum = {1'b0, i_last} + (IDX_W+1)'(i);
      if (w_sum >= C_NPORTS) begin
        w_sum = w_sum - C_NPORTS;
      end
      if (!o_valid && i_req[w_sum[IDX_W-1:0]]) begin
        o_valid = 1'b1;
        o_grant = w_sum[IDX_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/eth_tx_arbiter.sv
`default_nettype none
// ==========================================================================
// Module   : eth_tx_arbiter
// Summary  : Merges N AXI-Stream frame sources into one MAC TX stream.
//            Whole frames are granted round-robin, passed through a single
//            output register, and truncated (tagged bad) at MAX_BEATS.
// Revision : 1.0 - initial release
// ==========================================================================
module eth_tx_arbiter
  import eth_pkg::*;
#(
  parameter int N_PORTS   = 2,
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = C_MAX_BEATS
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_PORTS*DATA_W-1:0]  s_tdata,
  input  logic [N_PORTS-1:0]         s_tvalid,
  input  logic [N_PORTS-1:0]         s_tlast,
  input  logic [N_PORTS-1:0]         s_tuser,
  output logic [N_PORTS-1:0]         s_tready,
  output logic [DATA_W-1:0]          m_tdata,
  output logic                       m_tvalid,
  output logic                       m_tlast,
  output logic                       m_tuser,
  input  logic                       m_tready,
  output logic [$clog2(N_PORTS)-1:0] grant_id,
  output logic                       busy,
  output logic                       oversize
);

  localparam int                IDX_W       = $clog2(N_PORTS);
  localparam int                CNT_W       = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0]  C_LAST_BEAT = CNT_W'(MAX_BEATS - 1);
  localparam logic [IDX_W-1:0]  C_PTR_RST   = IDX_W'(N_PORTS - 1);

  arb_state_e         r_state;
  arb_state_e         w_state_next;
  logic [IDX_W-1:0]   r_grant;
  logic [IDX_W-1:0]   r_last_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_m_tdata;
  logic               r_m_tvalid;
  logic               r_m_tlast;
  logic               r_m_tuser;
  logic               r_oversize;

  logic [IDX_W-1:0]   w_arb_grant;
  logic               w_arb_valid;
  logic [DATA_W-1:0]  w_sel_data;
  logic               w_sel_valid;
  logic               w_sel_last;
  logic               w_sel_user;
  logic               w_out_free;
  logic               w_sel_ready;
  logic               w_accept;
  logic               w_trunc;

  eth_rr_arbiter #(
    .N_PORTS (N_PORTS),
    .IDX_W   (IDX_W)
  ) u_rr (
    .i_req   (s_tvalid),
    .i_last  (r_last_ptr),
    .o_grant (w_arb_grant),
    .o_valid (w_arb_valid)
  );

  // Route the granted source, derive its ready and the truncation condition
  always_comb begin
    w_sel_valid = s_tvalid[r_grant];
    w_sel_last  = s_tlast[r_grant];
    w_sel_user  = s_tuser[r_grant];
    w_sel_data  = s_tdata[int'(r_grant)*DATA_W +: DATA_W];
    w_out_free  = !r_m_tvalid || m_tready;
    w_sel_ready = (r_state == ST_XFER) ? w_out_free : (r_state == ST_DROP);
    w_accept    = w_sel_valid && w_sel_ready;
    // The MAX_BEATS-th beat without tlast closes the frame early
    w_trunc     = (r_state == ST_XFER) && w_accept && !w_sel_last && (r_cnt == C_LAST_BEAT);
    s_tready          = '0;
    s_tready[r_grant] = w_sel_ready;
  end

  // Next-state logic; every frame ends in IDLE so each new grant costs one bubble cycle
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_arb_valid) w_state_next = ST_XFER;
      ST_XFER: begin
        if (w_accept && w_sel_last) begin
          w_state_next = ST_IDLE;
        end else if (w_trunc) begin
          w_state_next = ST_DROP;
        end
      end
      ST_DROP: if (w_accept && w_sel_last) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // Grant capture and per-frame beat counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_grant    <= '0;
      r_last_ptr <= C_PTR_RST;
      r_cnt      <= '0;
    end else if ((r_state == ST_IDLE) && w_arb_valid) begin
      r_grant    <= w_arb_grant;
      r_last_ptr <= w_arb_grant;
      r_cnt      <= '0;
    end else if ((r_state == ST_XFER) && w_accept) begin
      r_cnt      <= r_cnt + CNT_W'(1);
    end
  end

  // Single-entry output register; a beat is only accepted when this slot is free
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_m_tdata  <= '0;
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_m_tuser  <= 1'b0;
    end else if ((r_state == ST_XFER) && w_accept) begin
      r_m_tdata  <= w_sel_data;
      r_m_tvalid <= 1'b1;
      r_m_tlast  <= w_sel_last || w_trunc;
      r_m_tuser  <= w_sel_user || w_trunc;
    end else if (m_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  // One-cycle truncation flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_oversize <= 1'b0;
    else          r_oversize <= w_trunc;
  end

  assign m_tdata  = r_m_tdata;
  assign m_tvalid = r_m_tvalid;
  assign m_tlast  = r_m_tlast;
  assign m_tuser  = r_m_tuser;
  assign grant_id = r_grant;
  assign busy     = (r_state != ST_IDLE);
  assign oversize = r_oversize;

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_arbiter.sv
`default_nettype none
// ==========================================================================
// Module   : tb_eth_tx_arbiter
// Summary  : Self-checking bench for eth_tx_arbiter. Sources are driven
//            from per-port beat queues; a frame-level scoreboard predicts
//            the merged output stream from the beats each source handed over.
// Revision : 1.0 - initial release
// ==========================================================================
module tb_eth_tx_arbiter;

  localparam int NP   = 3;
  localparam int DW   = 8;
  localparam int MAXB = 8;
  localparam int IW   = $clog2(NP);

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [NP*DW-1:0] s_tdata;
  logic [NP-1:0]   s_tvalid, s_tlast, s_tuser, s_tready;
  logic [DW-1:0]   m_tdata;
  logic            m_tvalid, m_tlast, m_tuser, m_tready;
  logic [IW-1:0]   grant_id;
  logic            busy, oversize;

  eth_tx_arbiter #(
    .N_PORTS   (NP),
    .DATA_W    (DW),
    .MAX_BEATS (MAXB)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tuser  (s_tuser),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast),
    .m_tuser  (m_tuser),
    .m_tready (m_tready),
    .grant_id (grant_id),
    .busy     (busy),
    .oversize (oversize)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus and reference model state
  beat_t         drv_q [NP][$];
  beat_t         exp_q [$];
  int            frm_ports [$];
  logic [NP-1:0] hold;
  int            cyc = 0;
  int            vld_pct, rdy_mode;
  bit            frm_open, frm_drop;
  int            frm_port, frm_cnt, last_end, last_gap;
  bit            ovs_pend, prev_stall, fwd_prev;
  logic [31:0]   prev_out;
  logic [7:0]    fwd_data;
  int            n_out, n_ovs, exp_trunc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pk(input beat_t b);
    return {22'd0, b};
  endfunction

  function automatic bit pending();
    bit r = frm_open;
    for (int p = 0; p < NP; p++) if (drv_q[p].size() > 0) r = 1'b1;
    return r;
  endfunction

  task automatic add_frame(input int p, input int len, input int base, input bit bad);
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b.d = 8'(base + i);
      b.l = (i == len - 1);
      b.u = bad ? 1'($urandom) : 1'b0;
      drv_q[p].push_back(b);
    end
    if (len > MAXB) exp_trunc++;
  endtask

  // Present queue heads; a beat offered but not taken stays offered unchanged
  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      if (drv_q[p].size() > 0 && (hold[p] || $urandom_range(99) < 32'(vld_pct))) begin
        s_tvalid[p]           = 1'b1;
        s_tdata[p*DW +: DW]   = drv_q[p][0].d;
        s_tlast[p]            = drv_q[p][0].l;
        s_tuser[p]            = drv_q[p][0].u;
      end else begin
        s_tvalid[p]           = 1'b0;
        s_tdata[p*DW +: DW]   = 8'($urandom);
        s_tlast[p]            = 1'($urandom);
        s_tuser[p]            = 1'($urandom);
      end
    end
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      default: m_tready = ($urandom_range(99) < 60);
    endcase
  endtask

  // Evaluate handshakes that the coming rising edge will see, and the registered outputs
  task automatic eval_cycle();
    logic [NP-1:0] fire;
    beat_t ib, e;
    logic [31:0] ob;
    chk("oversize", 32'(oversize), 32'(ovs_pend));
    if (oversize) n_ovs++;
    ovs_pend = 1'b0;
    if (prev_stall) begin
      chk("stall_valid", 32'(m_tvalid), 1);
      chk("stall_hold", {22'd0, m_tdata, m_tlast, m_tuser}, prev_out);
    end
    if (fwd_prev) begin
      chk("latency_valid", 32'(m_tvalid), 1);
      chk("latency_data", 32'(m_tdata), 32'(fwd_data));
    end
    chk("ready_onehot", 32'($countones(s_tready) <= 1), 1);
    ob = {22'd0, m_tdata, m_tlast, m_tuser};
    if (m_tvalid && m_tready) begin
      n_out++;
      chk("out_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_beat", ob, pk(e));
      end
    end
    prev_stall = m_tvalid && !m_tready;
    prev_out   = ob;
    fwd_prev   = 1'b0;
    fire       = s_tvalid & s_tready;
    for (int p = 0; p < NP; p++) begin
      if (fire[p]) begin
        ib = drv_q[p].pop_front();
        chk("accept_busy", 32'(busy), 1);
        chk("accept_grant", 32'(grant_id), p);
        if (!frm_open) begin
          frm_open = 1'b1;
          frm_drop = 1'b0;
          frm_port = p;
          frm_cnt  = 0;
          last_gap = cyc - last_end;
          chk("bubble", 32'(last_gap >= 2), 1);
          frm_ports.push_back(p);
        end else begin
          chk("interleave", p, frm_port);
        end
        if (!frm_drop) begin
          frm_cnt++;
          fwd_prev = 1'b1;
          fwd_data = ib.d;
          if (frm_cnt == MAXB && !ib.l) begin
            exp_q.push_back('{d: ib.d, l: 1'b1, u: 1'b1});
            ovs_pend = 1'b1;
            frm_drop = 1'b1;
          end else begin
            exp_q.push_back(ib);
            if (ib.l) begin frm_open = 1'b0; last_end = cyc; end
          end
        end else if (ib.l) begin
          frm_open = 1'b0;
          last_end = cyc;
        end
      end
    end
    hold = s_tvalid & ~fire;
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    drive();
    #1;
    eval_cycle();
  endtask

  task automatic clear_model();
    for (int p = 0; p < NP; p++) drv_q[p].delete();
    exp_q.delete();
    frm_ports.delete();
    hold = '0; frm_open = 0; frm_drop = 0; ovs_pend = 0; prev_stall = 0; fwd_prev = 0;
    last_end = -100; n_out = 0; n_ovs = 0; exp_trunc = 0;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    s_tvalid = '0; s_tdata = '0; s_tlast = '0; s_tuser = '0; m_tready = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_tvalid", 32'(m_tvalid), 0);
    chk("rst_m_tdata", 32'(m_tdata), 0);
    chk("rst_m_tlast_tuser", 32'({m_tlast, m_tuser}), 0);
    chk("rst_s_tready", 32'(s_tready), 0);
    chk("rst_busy_oversize", 32'({busy, oversize}), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run_until_done(input int budget);
    int n = 0;
    while ((pending() || exp_q.size() > 0 || m_tvalid) && n < budget) begin
      step();
      n++;
    end
    chk("timeout", 32'(n < budget), 1);
    repeat (3) step();
    chk("idle_busy", 32'(busy), 0);
    chk("idle_ready", 32'(s_tready), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=time_limit expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    vld_pct  = 100;
    rdy_mode = 0;

    // Single 4-beat frame, sink always ready
    do_reset();
    add_frame(0, 4, 'h11, 0);
    run_until_done(100);
    chk("t030_beats", n_out, 4);
    chk("t030_frames", frm_ports.size(), 1);

    // Two sources valid from reset: port0 first, one bubble, then port1
    do_reset();
    add_frame(0, 3, 'h21, 0);
    add_frame(1, 3, 'h31, 0);
    run_until_done(100);
    chk("t031_first", frm_ports[0], 0);
    chk("t031_second", frm_ports[1], 1);
    chk("t031_gap", last_gap, 2);

    // Both sources continuously requesting: grants alternate
    do_reset();
    for (int k = 0; k < 3; k++) begin
      add_frame(0, 2, 'h40 + 2 * k, 0);
      add_frame(1, 2, 'hC0 + 2 * k, 0);
    end
    run_until_done(200);
    chk("t032_frames", frm_ports.size(), 6);
    for (int i = 0; i < frm_ports.size(); i++) chk("t032_order", frm_ports[i], i % 2);

    // Sink ready toggling every cycle through an 8-beat frame
    do_reset();
    rdy_mode = 1;
    add_frame(0, 8, 'h50, 0);
    run_until_done(100);
    chk("t033_beats", n_out, 8);

    // Truncation boundary: 10 beats (cut), exactly MAXB beats (kept), MAXB+1 beats (cut)
    do_reset();
    rdy_mode = 0;
    add_frame(0, 10, 'h60, 0);
    add_frame(0, MAXB, 'h70, 0);
    add_frame(0, MAXB + 1, 'h80, 0);
    run_until_done(200);
    chk("t034_beats", n_out, 3 * MAXB);
    chk("t034_oversize", n_ovs, 2);

    // Asynchronous reset in the middle of a frame
    do_reset();
    add_frame(0, 5, 'h90, 0);
    n = 0;
    while (!(frm_open && frm_cnt >= 2) && n < 20) begin
      step();
      n++;
    end
    chk("t035_reach_beat2", 32'(n < 20), 1);
    @(posedge clk);
    #2;
    chk("t035_pre_busy", 32'(busy), 1);
    reset_n = 1'b0;
    #1;
    chk("t035_async_valid", 32'(m_tvalid), 0);
    chk("t035_async_tlast", 32'(m_tlast), 0);
    chk("t035_async_data", 32'(m_tdata), 0);
    chk("t035_async_busy", 32'(busy), 0);
    chk("t035_async_ready", 32'(s_tready), 0);
    chk("t035_async_grant", 32'(grant_id), 0);
    do_reset();
    add_frame(1, 2, 'hA0, 0);
    add_frame(2, 2, 'hA8, 0);
    add_frame(0, 2, 'hB0, 0);
    run_until_done(100);
    chk("t035_first", frm_ports[0], 0);
    chk("t035_second", frm_ports[1], 1);
    chk("t035_third", frm_ports[2], 2);

    // Randomized traffic: gaps on sources, random sink backpressure, random lengths/tuser
    do_reset();
    vld_pct  = 70;
    rdy_mode = 2;
    for (int f = 0; f < 40; f++) begin
      add_frame($urandom_range(NP - 1), $urandom_range(1, 12), $urandom_range(255), 1);
    end
    n = exp_trunc;
    run_until_done(20000);
    chk("rand_frames", frm_ports.size(), 40);
    chk("rand_oversize", n_ovs, n);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
